// File: rtl/alu_result_serializer.sv
// Captures an ALU result plus status flags on start and streams them out one byte
// per valid/ready handshake, optionally followed by a flag byte.
module alu_result_serializer #(
   parameter int DATA_W        = 32,
   parameter int MSB_FIRST     = 1,
   parameter int INCLUDE_FLAGS = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] result_in,
   input  logic [3:0]        flags_in,
   output logic [7:0]        byte_out,
   output logic              byte_valid,
   input  logic              byte_ready,
   output logic              byte_last,
   output logic              busy,
   output logic              done,
   output logic              overrun
);

   localparam int NUM_BYTES = DATA_W / 8 + ((INCLUDE_FLAGS != 0) ? 1 : 0);
   localparam int CNT_W     = $clog2(NUM_BYTES + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t            state, state_next;
   logic [DATA_W-1:0] shadow;
   logic [3:0]        flags_sh;
   logic [CNT_W-1:0]  cnt;
   logic              accept;
   logic              xfer;
   logic              at_last;

   assign at_last = (cnt == LAST_IDX);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_next = state;
      accept     = 1'b0;
      xfer       = 1'b0;
      byte_valid = 1'b0;
      byte_out   = '0;
      byte_last  = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = SEND;
            end
         end
         SEND: begin
            busy       = 1'b1;
            byte_valid = 1'b1;
            byte_last  = at_last;
            xfer       = byte_ready;
            // The shadow is shifted on each transfer, so the outgoing byte sits at a fixed end.
            if (INCLUDE_FLAGS != 0 && at_last)
               byte_out = {4'b0000, flags_sh};
            else if (MSB_FIRST != 0)
               byte_out = shadow[DATA_W-1 -: 8];
            else
               byte_out = shadow[7:0];
            if (xfer && at_last)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) begin
         state    <= IDLE;
         // NOTE: the shadow is reset as well, so a truncated frame leaves no stale data behind.
         shadow   <= '0;
         flags_sh <= '0;
         cnt      <= '0;
         done     <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         state <= state_next;
         done  <= xfer && at_last;
         if (accept) begin
            shadow   <= result_in;
            flags_sh <= flags_in;
            cnt      <= '0;
            overrun  <= 1'b0;
         end else begin
            if (xfer) begin
               cnt <= cnt + CNT_W'(1);
               if (MSB_FIRST != 0)
                  shadow <= shadow << 8;
               else
                  shadow <= shadow >> 8;
            end
            if (start && state == SEND)
               overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed bench for alu_result_serializer: table-driven handshake vectors plus
// hand-written sequences for overrun, mid-frame reset and back-to-back frames.
module tb_alu_result_serializer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, byte_ready;
   logic [31:0] result_in;
   logic [3:0]  flags_in;
   logic [7:0]  byte_out;
   logic        byte_valid, byte_last, busy, done, overrun;

   logic        start2, byte_ready2;
   logic [31:0] result_in2;
   logic [7:0]  byte_out2;
   logic        byte_valid2, byte_last2, busy2, done2, overrun2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_result_serializer u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .result_in(result_in), .flags_in(flags_in),
      .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .byte_last(byte_last), .busy(busy), .done(done), .overrun(overrun)
   );

   alu_result_serializer #(.DATA_W(32), .MSB_FIRST(0), .INCLUDE_FLAGS(0)) u_lsb (
      .clk(clk), .rst_n(rst_n), .start(start2), .result_in(result_in2), .flags_in(4'b1111),
      .byte_out(byte_out2), .byte_valid(byte_valid2), .byte_ready(byte_ready2),
      .byte_last(byte_last2), .busy(busy2), .done(done2), .overrun(overrun2)
   );

   typedef struct {
      logic       start;
      logic       ready;
      logic       valid;
      logic [7:0] data;
      logic       last;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t       tbl[$];
   logic [7:0] recv[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".valid"}, 32'(byte_valid), 32'd0);
      check({tag, ".byte"},  32'(byte_out),   32'd0);
      check({tag, ".last"},  32'(byte_last),  32'd0);
      check({tag, ".busy"},  32'(busy),       32'd0);
   endtask

   task automatic check_byte(input string tag, input logic [7:0] b, input logic last);
      check({tag, ".valid"}, 32'(byte_valid), 32'd1);
      check({tag, ".byte"},  32'(byte_out),   32'(b));
      check({tag, ".last"},  32'(byte_last),  32'(last));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp_stream [10];
      logic [7:0] frame5 [5];

      rst_n = 1'b0; start = 1'b0; byte_ready = 1'b0; result_in = '0; flags_in = '0;
      start2 = 1'b0; byte_ready2 = 1'b0; result_in2 = '0;

      // Test 1: reset and idle
      repeat (2) @(posedge clk);
      tick();
      check_idle("rst");
      check("rst.done", 32'(done), 32'd0);
      check("rst.overrun", 32'(overrun), 32'd0);
      rst_n = 1'b1;
      repeat (3) begin
         tick();
         check_idle("idle");
         check("idle.done", 32'(done), 32'd0);
      end

      // Tests 2 and 3: full-rate frame, then the same frame under a stall pattern
      //             start ready valid data   last busy done
      tbl.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 1'b1, 8'h12, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 1'b1, 8'h34, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 1'b1, 8'h56, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 1'b1, 8'h78, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 1'b1, 8'h12, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h34, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h34, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 1'b1, 8'h34, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 8'h56, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 1'b1, 8'h56, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 1'b1, 8'h78, 1'b0, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});

      result_in = 32'h1234_5678;
      flags_in  = 4'b0001;
      for (int i = 0; i < tbl.size(); i++) begin
         tick();
         start      = tbl[i].start;
         byte_ready = tbl[i].ready;
         check($sformatf("tbl%0d.valid", i), 32'(byte_valid), 32'(tbl[i].valid));
         check($sformatf("tbl%0d.byte", i),  32'(byte_out),   32'(tbl[i].data));
         check($sformatf("tbl%0d.last", i),  32'(byte_last),  32'(tbl[i].last));
         check($sformatf("tbl%0d.busy", i),  32'(busy),       32'(tbl[i].busy));
         check($sformatf("tbl%0d.done", i),  32'(done),       32'(tbl[i].done));
         if (byte_valid && byte_ready) recv.push_back(byte_out);
      end
      exp_stream = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h01};
      check("recv.count", 32'(recv.size()), 32'd10);
      for (int i = 0; i < 10; i++)
         if (i < recv.size()) check($sformatf("recv%0d", i), 32'(recv[i]), 32'(exp_stream[i]));

      // Test 4: start while busy is ignored but flagged; next accepted start clears overrun
      tick();
      result_in = 32'hA5A5_A5A5; flags_in = 4'b0000; start = 1'b1; byte_ready = 1'b1;
      tick();
      start = 1'b0;
      check_byte("ovr.b0", 8'hA5, 1'b0);
      tick();
      start = 1'b1; result_in = 32'hFFFF_FFFF;
      check_byte("ovr.b1", 8'hA5, 1'b0);
      check("ovr.pre", 32'(overrun), 32'd0);
      tick();
      start = 1'b0;
      check("ovr.set", 32'(overrun), 32'd1);
      check_byte("ovr.b2", 8'hA5, 1'b0);
      tick();
      check_byte("ovr.b3", 8'hA5, 1'b0);
      tick();
      check_byte("ovr.flag", 8'h00, 1'b1);
      check("ovr.hold", 32'(overrun), 32'd1);
      tick();
      check("ovr.done", 32'(done), 32'd1);
      check("ovr.hold2", 32'(overrun), 32'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("ovr.clear", 32'(overrun), 32'd0);
      for (int i = 0; i < 4; i++) begin
         check_byte($sformatf("ff.b%0d", i), 8'hFF, 1'b0);
         tick();
      end
      check_byte("ff.flag", 8'h00, 1'b1);
      tick();
      check("ff.done", 32'(done), 32'd1);

      // Test 5: reset mid-frame abandons it, then a fresh frame starts from the top
      result_in = 32'h1234_5678; flags_in = 4'b0001; start = 1'b1;
      tick();
      start = 1'b0;
      check_byte("mrst.b0", 8'h12, 1'b0);
      tick();
      check_byte("mrst.b1", 8'h34, 1'b0);
      tick();
      check_byte("mrst.b2", 8'h56, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_idle("mrst.after");
      check("mrst.done", 32'(done), 32'd0);
      tick();
      check("mrst.done2", 32'(done), 32'd0);
      check_idle("mrst.idle");
      start = 1'b1;
      tick();
      start = 1'b0;
      frame5 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h01};
      for (int i = 0; i < 5; i++) begin
         check_byte($sformatf("mrst.f%0d", i), frame5[i], (i == 4) ? 1'b1 : 1'b0);
         tick();
      end
      check("mrst.fdone", 32'(done), 32'd1);
      byte_ready = 1'b0;

      // Test 6: LSB-first, no flag byte, back-to-back start in the done cycle
      result_in2 = 32'h1234_5678; start2 = 1'b1; byte_ready2 = 1'b1;
      tick();
      start2 = 1'b0;
      check("lsb.b0", 32'(byte_out2), 32'h78);
      check("lsb.v0", 32'(byte_valid2), 32'd1);
      tick();
      check("lsb.b1", 32'(byte_out2), 32'h56);
      tick();
      check("lsb.b2", 32'(byte_out2), 32'h34);
      check("lsb.l2", 32'(byte_last2), 32'd0);
      tick();
      check("lsb.b3", 32'(byte_out2), 32'h12);
      check("lsb.l3", 32'(byte_last2), 32'd1);
      tick();
      check("lsb.done", 32'(done2), 32'd1);
      check("lsb.gapv", 32'(byte_valid2), 32'd0);
      check("lsb.gapb", 32'(byte_out2), 32'd0);
      check("lsb.busy", 32'(busy2), 32'd0);
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      check("lsb.f2v", 32'(byte_valid2), 32'd1);
      check("lsb.f2b", 32'(byte_out2), 32'h78);
      check("lsb.ovr", 32'(overrun2), 32'd0);
      repeat (4) tick();
      check("lsb.f2done", 32'(done2), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
